spi_txn_arbiter: RTL

Transaction-level controller that shares one `spi` byte-master core between `NREQ` requesters. It arbitrates round-robin, drives one active-low chip select per requester, and sequences a multi-byte burst through the core's `wr`/`spi_done`/`spi_idle` handshake. Each burst includes chip-select setup and hold intervals. It sits between the client blocks and the `spi` core; the core's `spi_clk`/`spi_mosi`/`spi_miso` go to pins untouched.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_rr_arbiter.sv | 27 ++
 rtl/spi_txn_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } arb_state_t;

  // Index following idx, wrapping at nreq (up to 8 requesters).
  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int nreq);
    return (int'(idx) + 1 >= nreq) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, with wrap.
module spi_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_vld
);
  int idx;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    // Descending scan so the smallest offset from rr_ptr is the one that sticks.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req[idx]) begin
        grant_idx = IDXW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI byte-master core among NREQ requesters with CS setup/hold framing.
// Optional inter-burst CS-high gap enabled by defining SPI_ARB_GUARD_EN.
//
// state    | meaning
// ST_IDLE  | all ss_n high, looking for a request
// ST_SETUP | ss_n low, counting SETUP_CYC before the first byte
// ST_LOAD  | waiting for core idle, then issue one wr strobe
// ST_WAIT  | byte in flight, waiting for spi_done
// ST_HOLD  | counting HOLD_CYC after the last byte, then release ss_n
// ST_GAP   | (guard build) ss_n held high for GAP_CYC before next grant
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LENW      = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*LENW-1:0]       len,
  input  logic [NREQ*SPI_BYTE_W-1:0] tx_data,
  output logic [NREQ-1:0]            tx_ack,
  output logic [SPI_BYTE_W-1:0]      rx_data,
  output logic [NREQ-1:0]            rx_valid,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            ss_n,
  output logic [SPI_BYTE_W-1:0]      spi_din,
  output logic                       spi_wr,
  input  logic [SPI_BYTE_W-1:0]      spi_dout,
  input  logic                       spi_done,
  input  logic                       spi_idle
);
  localparam int IDXW = $clog2(NREQ);
  localparam int MAXC = (SETUP_CYC > HOLD_CYC) ?
                        ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                        ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
  localparam int DLYW = $clog2(MAXC + 1);

  arb_state_t            state, state_nxt;
  logic [IDXW-1:0]       grant, grant_nxt, rr_ptr, rr_nxt, pick_idx;
  logic                  pick_vld;
  logic [LENW-1:0]       cnt, cnt_nxt;
  logic [DLYW-1:0]       dly, dly_nxt;
  logic [NREQ-1:0]       pick_oh, grant_oh;
  logic [NREQ-1:0]       ss_n_nxt, tx_ack_nxt, rx_valid_nxt, done_nxt;
  logic [SPI_BYTE_W-1:0] rx_data_nxt, spi_din_nxt;
  logic                  spi_wr_nxt;

  spi_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant_idx (pick_idx),
    .grant_vld (pick_vld)
  );

  assign pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      dly      <= '0;
      ss_n     <= '1;
      tx_ack   <= '0;
      rx_valid <= '0;
      done     <= '0;
      rx_data  <= '0;
      spi_din  <= '0;
      spi_wr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      cnt      <= cnt_nxt;
      dly      <= dly_nxt;
      ss_n     <= ss_n_nxt;
      tx_ack   <= tx_ack_nxt;
      rx_valid <= rx_valid_nxt;
      done     <= done_nxt;
      rx_data  <= rx_data_nxt;
      spi_din  <= spi_din_nxt;
      spi_wr   <= spi_wr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_nxt       = rr_ptr;
    cnt_nxt      = cnt;
    dly_nxt      = dly;
    ss_n_nxt     = ss_n;
    tx_ack_nxt   = '0;
    rx_valid_nxt = '0;
    done_nxt     = '0;
    rx_data_nxt  = rx_data;
    spi_din_nxt  = spi_din;
    spi_wr_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_idx;
          cnt_nxt   = len[pick_idx*LENW +: LENW];
          ss_n_nxt  = ~pick_oh;
          dly_nxt   = DLYW'(SETUP_CYC - 1);
          rr_nxt    = IDXW'(rr_next(3'(pick_idx), NREQ));
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (dly == '0) state_nxt = ST_LOAD;
        else           dly_nxt   = dly - DLYW'(1);
      end
      ST_LOAD: begin
        if (spi_idle) begin
          spi_wr_nxt  = 1'b1;
          spi_din_nxt = tx_data[grant*SPI_BYTE_W +: SPI_BYTE_W];
          tx_ack_nxt  = grant_oh;
          state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (spi_done) begin
          rx_data_nxt  = spi_dout;
          rx_valid_nxt = grant_oh;
          if (cnt == '0) begin
            dly_nxt   = DLYW'(HOLD_CYC - 1);
            state_nxt = ST_HOLD;
          end else begin
            cnt_nxt   = cnt - LENW'(1);
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (dly == '0) begin
          ss_n_nxt = '1;
          done_nxt = grant_oh;
`ifdef SPI_ARB_GUARD_EN
          dly_nxt   = DLYW'(GAP_CYC - 1);
          state_nxt = ST_GAP;
`else
          state_nxt = ST_IDLE;
`endif
        end else begin
          dly_nxt = dly - DLYW'(1);
        end
      end
      ST_GAP: begin
        if (dly == '0) state_nxt = ST_IDLE;
        else           dly_nxt   = dly - DLYW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
